// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Issue/response sequencer for a combinational floating-point unit. A single
// operation is accepted at a time. Its fields are registered onto the FP unit
// drive bus, and a per-op latency counter decides the edge on which the FP
// unit result is sampled. The result is then presented on a valid/ready
// response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The issue side never depends on
// in_req_valid to form out_req_ready. The response side holds valid and all
// payload fields stable until the transfer happens (or until a flush/reset
// drops the response).
//
// Ports
//   in_clk, in_rst_n            clock, asynchronous active-low reset
//   in_req_valid/out_req_ready  issue handshake
//   in_rs1, in_rs2, in_FPU_Op, in_fmt, in_addsub_ctrl,
//   in_ctrl_minmax_sgnj_cmp, in_rd        issue payload
//   in_flush                    abandon the operation in flight
//   out_fpu_*                   registered drive to the FP unit
//   in_fpu_data                 FP unit result
//   out_resp_valid/in_resp_ready          response handshake
//   out_resp_data/rd/int/illegal          response payload
//   out_busy                    high whenever the FSM is not IDLE
//   out_dbg_state               raw FSM state (0 IDLE, 1 EXEC, 2 DONE)
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADDSUB = 2,
    parameter int unsigned LAT_MUL    = 3,
    parameter int unsigned LAT_DIV    = 12,
    parameter int unsigned LAT_MISC   = 1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [3:0]  in_FPU_Op,
    input  logic [1:0]  in_fmt,
    input  logic        in_addsub_ctrl,
    input  logic [2:0]  in_ctrl_minmax_sgnj_cmp,
    input  logic [4:0]  in_rd,
    input  logic        in_flush,
    output logic [31:0] out_fpu_rs1,
    output logic [31:0] out_fpu_rs2,
    output logic [3:0]  out_fpu_op,
    output logic [1:0]  out_fpu_fmt,
    output logic        out_fpu_addsub,
    output logic [2:0]  out_fpu_ctrl,
    input  logic [63:0] in_fpu_data,
    output logic        out_resp_valid,
    output logic [63:0] out_resp_data,
    output logic [4:0]  out_resp_rd,
    output logic        out_resp_int,
    output logic        out_resp_illegal,
    input  logic        in_resp_ready,
    output logic        out_busy,
    output logic [1:0]  out_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter preload values: the counter runs down to zero and the capture
    // happens on the edge that finds it at zero, so LAT-1 gives LAT edges.
    localparam logic [3:0] CNT_ADDSUB = 4'(LAT_ADDSUB - 1);
    localparam logic [3:0] CNT_MUL    = 4'(LAT_MUL - 1);
    localparam logic [3:0] CNT_DIV    = 4'(LAT_DIV - 1);
    localparam logic [3:0] CNT_MISC   = 4'(LAT_MISC - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] fpu_rs1_q, fpu_rs1_d;
    logic [31:0] fpu_rs2_q, fpu_rs2_d;
    logic [3:0]  fpu_op_q, fpu_op_d;
    logic [1:0]  fpu_fmt_q, fpu_fmt_d;
    logic        fpu_addsub_q, fpu_addsub_d;
    logic [2:0]  fpu_ctrl_q, fpu_ctrl_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_int_q, resp_int_d;
    logic        resp_illegal_q, resp_illegal_d;

    logic        accept;
    logic        op_illegal;
    logic        op_int;

    function automatic logic [3:0] lat_cnt(input logic [3:0] op);
        logic [3:0] c;
        case (op)
            4'b0000: c = CNT_ADDSUB;
            4'b0001: c = CNT_MUL;
            4'b0010: c = CNT_DIV;
            default: c = CNT_MISC;
        endcase
        return c;
    endfunction

    // in_rst_n is folded in so ready is low during reset, not only after
    // the asynchronous clear has settled the state.
    assign out_req_ready = ((state_q == IDLE) || ((state_q == DONE) && in_resp_ready))
                           && !in_flush && in_rst_n;
    assign accept        = in_req_valid && out_req_ready;

    // Result classification is taken from the registered op, which is
    // stable for the whole operation.
    assign op_illegal = fpu_op_q[3];
    assign op_int     = (fpu_op_q == 4'b0100) || (fpu_op_q == 4'b0110);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        fpu_rs1_d      = fpu_rs1_q;
        fpu_rs2_d      = fpu_rs2_q;
        fpu_op_d       = fpu_op_q;
        fpu_fmt_d      = fpu_fmt_q;
        fpu_addsub_d   = fpu_addsub_q;
        fpu_ctrl_d     = fpu_ctrl_q;
        resp_data_d    = resp_data_q;
        resp_rd_d      = resp_rd_q;
        resp_int_d     = resp_int_q;
        resp_illegal_d = resp_illegal_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            EXEC: begin
                if (in_flush) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_data_d    = op_illegal ? 64'd0 : in_fpu_data;
                    resp_rd_d      = rd_q;
                    resp_int_d     = op_int;
                    resp_illegal_d = op_illegal;
                    state_d        = DONE;
                end
            end
            DONE: begin
                // A flush here still lets a same-edge handshake complete;
                // either way the response is gone after this edge.
                if (in_flush || in_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept can only occur in IDLE or in DONE during a response
        // handshake, so it overrides the IDLE target chosen above.
        if (accept) begin
            fpu_rs1_d    = in_rs1;
            fpu_rs2_d    = in_rs2;
            fpu_op_d     = in_FPU_Op;
            fpu_fmt_d    = in_fmt;
            fpu_addsub_d = in_addsub_ctrl;
            fpu_ctrl_d   = in_ctrl_minmax_sgnj_cmp;
            rd_d         = in_rd;
            cnt_d        = lat_cnt(in_FPU_Op);
            state_d      = EXEC;
        end

        resp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            rd_q           <= 5'd0;
            fpu_rs1_q      <= 32'd0;
            fpu_rs2_q      <= 32'd0;
            fpu_op_q       <= 4'd0;
            fpu_fmt_q      <= 2'd0;
            fpu_addsub_q   <= 1'b0;
            fpu_ctrl_q     <= 3'd0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 64'd0;
            resp_rd_q      <= 5'd0;
            resp_int_q     <= 1'b0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_q           <= rd_d;
            fpu_rs1_q      <= fpu_rs1_d;
            fpu_rs2_q      <= fpu_rs2_d;
            fpu_op_q       <= fpu_op_d;
            fpu_fmt_q      <= fpu_fmt_d;
            fpu_addsub_q   <= fpu_addsub_d;
            fpu_ctrl_q     <= fpu_ctrl_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_rd_q      <= resp_rd_d;
            resp_int_q     <= resp_int_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    assign out_fpu_rs1      = fpu_rs1_q;
    assign out_fpu_rs2      = fpu_rs2_q;
    assign out_fpu_op       = fpu_op_q;
    assign out_fpu_fmt      = fpu_fmt_q;
    assign out_fpu_addsub   = fpu_addsub_q;
    assign out_fpu_ctrl     = fpu_ctrl_q;
    assign out_resp_valid   = resp_valid_q;
    assign out_resp_data    = resp_data_q;
    assign out_resp_rd      = resp_rd_q;
    assign out_resp_int     = resp_int_q;
    assign out_resp_illegal = resp_illegal_q;
    assign out_busy         = (state_q != IDLE);
    assign out_dbg_state    = state_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl
//
// Directed bench for fpu_issue_ctrl with default latencies (2/3/12/1).
// The FP unit stand-in drives in_fpu_data with a tag plus the number of the
// upcoming rising edge, so the captured value identifies the capture edge.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

    logic        in_clk;
    logic        in_rst_n;
    logic        in_req_valid;
    logic        out_req_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [3:0]  in_FPU_Op;
    logic [1:0]  in_fmt;
    logic        in_addsub_ctrl;
    logic [2:0]  in_ctrl_minmax_sgnj_cmp;
    logic [4:0]  in_rd;
    logic        in_flush;
    logic [31:0] out_fpu_rs1;
    logic [31:0] out_fpu_rs2;
    logic [3:0]  out_fpu_op;
    logic [1:0]  out_fpu_fmt;
    logic        out_fpu_addsub;
    logic [2:0]  out_fpu_ctrl;
    logic [63:0] in_fpu_data;
    logic        out_resp_valid;
    logic [63:0] out_resp_data;
    logic [4:0]  out_resp_rd;
    logic        out_resp_int;
    logic        out_resp_illegal;
    logic        in_resp_ready;
    logic        out_busy;
    logic [1:0]  out_dbg_state;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit data_mode = 1'b1;

    localparam logic [31:0] TAG = 32'hDA7A0000;

    fpu_issue_ctrl dut (
        .in_clk                  (in_clk),
        .in_rst_n                (in_rst_n),
        .in_req_valid            (in_req_valid),
        .out_req_ready           (out_req_ready),
        .in_rs1                  (in_rs1),
        .in_rs2                  (in_rs2),
        .in_FPU_Op               (in_FPU_Op),
        .in_fmt                  (in_fmt),
        .in_addsub_ctrl          (in_addsub_ctrl),
        .in_ctrl_minmax_sgnj_cmp (in_ctrl_minmax_sgnj_cmp),
        .in_rd                   (in_rd),
        .in_flush                (in_flush),
        .out_fpu_rs1             (out_fpu_rs1),
        .out_fpu_rs2             (out_fpu_rs2),
        .out_fpu_op              (out_fpu_op),
        .out_fpu_fmt             (out_fpu_fmt),
        .out_fpu_addsub          (out_fpu_addsub),
        .out_fpu_ctrl            (out_fpu_ctrl),
        .in_fpu_data             (in_fpu_data),
        .out_resp_valid          (out_resp_valid),
        .out_resp_data           (out_resp_data),
        .out_resp_rd             (out_resp_rd),
        .out_resp_int            (out_resp_int),
        .out_resp_illegal        (out_resp_illegal),
        .in_resp_ready           (in_resp_ready),
        .out_busy                (out_busy),
        .out_dbg_state           (out_dbg_state)
    );

    // Clock and edge numbering
    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) edge_n <= edge_n + 1;

    // Result stand-in: value seen at edge N is {TAG, N}
    always @(negedge in_clk) begin
        if (data_mode) in_fpu_data = {TAG, 32'(edge_n + 1)};
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  fmt;
        logic        addsub;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        int          lat;
        logic        is_int;
        logic        illegal;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [1:0] fmt, input logic addsub, input logic [2:0] ctrl,
                             input logic [4:0] rd);
        in_req_valid            = 1'b1;
        in_FPU_Op               = op;
        in_rs1                  = rs1;
        in_rs2                  = rs2;
        in_fmt                  = fmt;
        in_addsub_ctrl          = addsub;
        in_ctrl_minmax_sgnj_cmp = ctrl;
        in_rd                   = rd;
    endtask

    // Called at the negedge after the accept edge; returns edges from accept
    // to first visible response, or -1 on timeout. Also flags any cycle in
    // EXEC where busy is low or ready is high.
    task automatic wait_resp(input int e0, output int lat, output bit exec_ok);
        lat     = -1;
        exec_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_resp_valid) begin
                lat = edge_n - e0;
                break;
            end
            if (out_busy !== 1'b1 || out_req_ready !== 1'b0) exec_ok = 1'b0;
            @(negedge in_clk);
        end
    endtask

    task automatic release_resp(input string name);
        in_resp_ready = 1'b1;
        @(negedge in_clk);
        in_resp_ready = 1'b0;
        chk({name, "_idle_busy"}, 64'(out_busy), 64'd0);
        chk({name, "_idle_valid"}, 64'(out_resp_valid), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int e0;
        int lat;
        bit exec_ok;
        string nm;
        nm = $sformatf("vec%0d", idx);
        drive_req(v.op, v.rs1, v.rs2, v.fmt, v.addsub, v.ctrl, v.rd);
        e0 = edge_n + 1;
        #1;
        chk({nm, "_ready"}, 64'(out_req_ready), 64'd1);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        chk({nm, "_fpu_rs1"}, 64'(out_fpu_rs1), 64'(v.rs1));
        chk({nm, "_fpu_rs2"}, 64'(out_fpu_rs2), 64'(v.rs2));
        chk({nm, "_fpu_op"}, 64'(out_fpu_op), 64'(v.op));
        chk({nm, "_fpu_mod"}, {58'd0, out_fpu_fmt, out_fpu_addsub, out_fpu_ctrl},
            {58'd0, v.fmt, v.addsub, v.ctrl});
        wait_resp(e0, lat, exec_ok);
        chk({nm, "_exec_busy_noready"}, 64'(exec_ok), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'(v.lat));
        chk({nm, "_data"}, out_resp_data, v.illegal ? 64'd0 : {TAG, 32'(e0 + v.lat)});
        chk({nm, "_rd"}, 64'(out_resp_rd), 64'(v.rd));
        chk({nm, "_int"}, 64'(out_resp_int), 64'(v.is_int));
        chk({nm, "_illegal"}, 64'(out_resp_illegal), 64'(v.illegal));
        release_resp(nm);
    endtask

    initial begin
        int e0;
        int e1;
        int lat;
        bit ok;
        bit seen;

        // op, rs1, rs2, fmt, addsub, ctrl, rd, lat, int, illegal
        vecs[0]  = '{4'b0000, 32'h3F800000, 32'h40000000, 2'd0, 1'b1, 3'd0, 5'd1,  2,  1'b0, 1'b0};
        vecs[1]  = '{4'b0001, 32'h11111111, 32'h22222222, 2'd1, 1'b0, 3'd1, 5'd2,  3,  1'b0, 1'b0};
        vecs[2]  = '{4'b0010, 32'h40490FDB, 32'h3F000000, 2'd2, 1'b0, 3'd2, 5'd3,  12, 1'b0, 1'b0};
        vecs[3]  = '{4'b0011, 32'hAAAAAAAA, 32'h55555555, 2'd3, 1'b1, 3'd3, 5'd4,  1,  1'b0, 1'b0};
        vecs[4]  = '{4'b0100, 32'h00000001, 32'h00000002, 2'd0, 1'b0, 3'd4, 5'd7,  1,  1'b1, 1'b0};
        vecs[5]  = '{4'b0101, 32'hDEADBEEF, 32'hCAFEF00D, 2'd1, 1'b1, 3'd5, 5'd8,  1,  1'b0, 1'b0};
        vecs[6]  = '{4'b0110, 32'h12345678, 32'h9ABCDEF0, 2'd2, 1'b0, 3'd6, 5'd9,  1,  1'b1, 1'b0};
        vecs[7]  = '{4'b0111, 32'h0F0F0F0F, 32'hF0F0F0F0, 2'd3, 1'b1, 3'd7, 5'd10, 1,  1'b0, 1'b0};
        vecs[8]  = '{4'b1000, 32'h00000008, 32'h00000080, 2'd0, 1'b0, 3'd0, 5'd11, 1,  1'b0, 1'b1};
        vecs[9]  = '{4'b1010, 32'hFFFFFFFF, 32'h00000000, 2'd1, 1'b1, 3'd1, 5'd12, 1,  1'b0, 1'b1};
        vecs[10] = '{4'b1111, 32'h80000000, 32'h7FFFFFFF, 2'd2, 1'b0, 3'd2, 5'd31, 1,  1'b0, 1'b1};

        // Reset
        in_rst_n = 1'b0;
        in_req_valid = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_FPU_Op = '0; in_fmt = '0;
        in_addsub_ctrl = 1'b0; in_ctrl_minmax_sgnj_cmp = '0; in_rd = '0;
        in_flush = 1'b0; in_resp_ready = 1'b0; in_fpu_data = '0;
        repeat (3) @(negedge in_clk);
        in_req_valid = 1'b1;
        #1;
        chk("rst_ready", 64'(out_req_ready), 64'd0);
        chk("rst_busy", 64'(out_busy), 64'd0);
        chk("rst_resp_valid", 64'(out_resp_valid), 64'd0);
        chk("rst_fpu_rs1", 64'(out_fpu_rs1), 64'd0);
        chk("rst_resp_data", out_resp_data, 64'd0);
        in_req_valid = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);

        // Addsub with fixed model result
        data_mode = 1'b0;
        in_fpu_data = 64'h00000000_40400000;
        drive_req(4'b0000, 32'h3F800000, 32'h40000000, 2'd0, 1'b0, 3'd0, 5'd6);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        chk("add_valid_e1", 64'(out_resp_valid), 64'd0);
        @(negedge in_clk);
        chk("add_valid_e2_pre", 64'(out_resp_valid), 64'd0);
        @(negedge in_clk);
        chk("add_valid_e2", 64'(out_resp_valid), 64'd1);
        chk("add_data", out_resp_data, 64'h00000000_40400000);
        chk("add_int", 64'(out_resp_int), 64'd0);
        release_resp("add");
        data_mode = 1'b1;
        @(negedge in_clk);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Backpressure then back-to-back issue
        drive_req(4'b0001, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'd1, 1'b0, 3'd0, 5'd3);
        e0 = edge_n + 1;
        @(negedge in_clk);
        in_req_valid = 1'b0;
        wait_resp(e0, lat, ok);
        chk("bp_latency", 64'(lat), 64'd3);
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge in_clk);
            if (out_resp_valid !== 1'b1 || out_resp_data !== {TAG, 32'(e0 + 3)} ||
                out_resp_rd !== 5'd3 || out_resp_int !== 1'b0 || out_resp_illegal !== 1'b0)
                ok = 1'b0;
        end
        chk("bp_hold", 64'(ok), 64'd1);
        in_resp_ready = 1'b1;
        drive_req(4'b0000, 32'hC0FFEE00, 32'h00000077, 2'd0, 1'b1, 3'd0, 5'd9);
        e1 = edge_n + 1;
        #1;
        chk("b2b_ready", 64'(out_req_ready), 64'd1);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        in_resp_ready = 1'b0;
        chk("b2b_valid_drop", 64'(out_resp_valid), 64'd0);
        chk("b2b_state_exec", 64'(out_dbg_state), 64'd1);
        chk("b2b_fpu_rs1", 64'(out_fpu_rs1), 64'hC0FFEE00);
        wait_resp(e1, lat, ok);
        chk("b2b_latency", 64'(lat), 64'd2);
        chk("b2b_data", out_resp_data, {TAG, 32'(e1 + 2)});
        chk("b2b_rd", 64'(out_resp_rd), 64'd9);
        release_resp("b2b");

        // Flush during EXEC cycle 1 of a mul
        drive_req(4'b0001, 32'h1, 32'h2, 2'd0, 1'b0, 3'd0, 5'd4);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        in_flush = 1'b1;
        @(negedge in_clk);
        in_flush = 1'b0;
        chk("flush_exec_busy", 64'(out_busy), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_resp_valid) seen = 1'b1;
            @(negedge in_clk);
        end
        chk("flush_exec_no_resp", 64'(seen), 64'd0);

        // Flush with a request in IDLE
        drive_req(4'b0011, 32'h3, 32'h4, 2'd0, 1'b0, 3'd0, 5'd5);
        in_flush = 1'b1;
        #1;
        chk("flush_idle_ready", 64'(out_req_ready), 64'd0);
        @(negedge in_clk);
        chk("flush_idle_busy", 64'(out_busy), 64'd0);
        in_flush = 1'b0;

        // Flush in DONE: blocks a same-edge accept, returns to IDLE
        e0 = edge_n + 1;
        @(negedge in_clk);
        in_req_valid = 1'b0;
        wait_resp(e0, lat, ok);
        chk("flush_done_latency", 64'(lat), 64'd1);
        in_flush = 1'b1;
        in_resp_ready = 1'b1;
        in_req_valid = 1'b1;
        #1;
        chk("flush_done_ready", 64'(out_req_ready), 64'd0);
        @(negedge in_clk);
        in_flush = 1'b0;
        in_resp_ready = 1'b0;
        in_req_valid = 1'b0;
        chk("flush_done_busy", 64'(out_busy), 64'd0);
        chk("flush_done_valid", 64'(out_resp_valid), 64'd0);

        // Reset during DONE, then immediate accept after release
        drive_req(4'b0011, 32'h5, 32'h6, 2'd0, 1'b0, 3'd0, 5'd2);
        e0 = edge_n + 1;
        @(negedge in_clk);
        in_req_valid = 1'b0;
        wait_resp(e0, lat, ok);
        chk("rstd_pre_valid", 64'(out_resp_valid), 64'd1);
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("rstd_valid", 64'(out_resp_valid), 64'd0);
        chk("rstd_busy", 64'(out_busy), 64'd0);
        chk("rstd_ready", 64'(out_req_ready), 64'd0);
        chk("rstd_data", out_resp_data, 64'd0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        drive_req(4'b0000, 32'h77, 32'h88, 2'd0, 1'b0, 3'd0, 5'd5);
        e0 = edge_n + 1;
        #1;
        chk("rstd_first_ready", 64'(out_req_ready), 64'd1);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        chk("rstd_first_busy", 64'(out_busy), 64'd1);
        wait_resp(e0, lat, ok);
        chk("rstd_latency", 64'(lat), 64'd2);
        chk("rstd_data_after", out_resp_data, {TAG, 32'(e0 + 2)});
        chk("rstd_rd", 64'(out_resp_rd), 64'd5);
        release_resp("rstd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound in case a handshake never completes
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_ADDSUB, default 2: cycles from accept to result capture for op 4'b0000.
REQ-002 SHALL have parameter LAT_MUL, default 3: capture latency for op 4'b0001.
REQ-003 SHALL have parameter LAT_DIV, default 12: capture latency for op 4'b0010.
REQ-004 SHALL have parameter LAT_MISC, default 1: capture latency for all other ops; every LAT_* is legal only in the range 1..15.
REQ-005 SHALL have port in_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port in_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_req_valid, input, 1 bit: an issue request is present.
REQ-008 SHALL have port out_req_ready, output, 1 bit: the block accepts the request on this edge.
REQ-009 SHALL have ports in_rs1 and in_rs2, input, 32 bits each: operands.
REQ-010 SHALL have port in_FPU_Op, input, 4 bits: operation select.
REQ-011 SHALL have ports in_fmt (2 bits), in_addsub_ctrl (1 bit) and in_ctrl_minmax_sgnj_cmp (3 bits), all input: operation modifiers.
REQ-012 SHALL have port in_rd, input, 5 bits: destination register tag.
REQ-013 SHALL have port in_flush, input, 1 bit: abandon the in-flight operation.
REQ-014 SHALL have ports out_fpu_rs1/out_fpu_rs2 (32), out_fpu_op (4), out_fpu_fmt (2), out_fpu_addsub (1) and out_fpu_ctrl (3), all output: registered drive to the combinational FP unit.
REQ-015 SHALL have port in_fpu_data, input, 64 bits: FP unit result.
REQ-016 SHALL have ports out_resp_valid (1), out_resp_data (64), out_resp_rd (5), out_resp_int (1) and out_resp_illegal (1), all output, plus in_resp_ready, input, 1: the response channel.
REQ-017 SHALL have port out_busy, output, 1 bit: high when state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, EXEC and DONE.
REQ-019 SHALL drive out_req_ready = ((state==IDLE) or (state==DONE and in_resp_ready)) and not in_flush and in_rst_n.
REQ-020 On an accept edge E0 (in_req_valid and out_req_ready), SHALL:
- latch every request field into the out_fpu_* registers and the rd tag;
- load the 4-bit counter with LAT_x-1;
- enter EXEC.
REQ-021 SHALL hold the out_fpu_* registers stable from E0 until the next accept.
REQ-022 In EXEC, at each edge, SHALL decrement the counter when it is non-zero; when it is zero, SHALL capture in_fpu_data into out_resp_data and enter DONE, so the capture occurs at edge E0+LAT_x.
REQ-023 In DONE, SHALL assert out_resp_valid and hold out_resp_data, out_resp_rd, out_resp_int and out_resp_illegal stable until in_resp_ready is high.
REQ-024 In DONE with in_resp_ready high and no new accept, SHALL return to IDLE and deassert out_resp_valid.
REQ-025 In DONE, when a response handshake and a new accept occur on the same edge, SHALL go directly to EXEC (back-to-back issue, no bubble).
REQ-026 SHALL set out_resp_int = 1 for ops 4'b0100 (compare) and 4'b0110 (convert), and 0 otherwise.
REQ-027 For ops 4'b1000-4'b1111, SHALL use LAT_MISC, force out_resp_data to 0 and set out_resp_illegal = 1; for legal ops, out_resp_illegal = 0.
REQ-028 in_flush in EXEC SHALL return to IDLE on the next edge and discard the capture; no response is produced.
REQ-029 in_flush in DONE SHALL return to IDLE on the next edge; a response handshake on that same edge still counts as delivered.
REQ-030 in_flush in IDLE SHALL block acceptance and SHALL not change state.
REQ-031 SHALL update out_busy from state only; out_busy is 0 exactly when state is IDLE.

Reset
REQ-032 While in_rst_n is low, SHALL force state to IDLE, the counter to 0, and all out_fpu_* and out_resp_* registers to 0.
REQ-033 While in_rst_n is low, SHALL force out_req_ready and out_busy to 0.
REQ-034 Reset asserted mid-EXEC or mid-DONE SHALL drop the operation with no response after release.
REQ-035 On the first edge after in_rst_n rises, SHALL be able to accept a request.

Verification
REQ-036 Addsub: accept op 0000 with rs1=0x3F800000 and rs2=0x40000000 at edge 0, model returns 0x00000000_40400000 -> out_resp_valid rises after edge 2 with that data, out_resp_int=0.
REQ-037 Div: accept op 0010 -> out_busy is 1 for 12 edges; the capture edge is E0+12; out_req_ready is 0 throughout.
REQ-038 Backpressure: in_resp_ready=0 for 5 cycles in DONE -> response fields held constant; then a new request plus in_resp_ready=1 -> both handshakes on the same edge, and the next op enters EXEC.
REQ-039 Compare (op 0100, rd=7) -> out_resp_int=1 and out_resp_rd=7; illegal op 1010 -> out_resp_data=0 and out_resp_illegal=1 after 1 cycle.
REQ-040 Flush at EXEC cycle 1 of a mul -> IDLE next edge with no out_resp_valid pulse; flush with in_req_valid in IDLE -> no accept.
REQ-041 Drop in_rst_n during DONE -> out_resp_valid=0 immediately (asynchronous); after release, the next request completes normally.
